// File: rtl/bus_c_writeback_if.sv
// Bus C producer-to-writeback handshake.
//   wb_valid : producer presents a write this cycle
//   wb_ready : writeback buffer can take a write (depends only on registered state)
//   wb_data  : 8-bit write data
//   wb_dest  : destination register index (don't-care when MC = 1)
//   MC       : destination select, 0 = register file, 1 = program counter
// Handshake: a write transfers on a rising edge where wb_valid && wb_ready are
// both high; the producer keeps data/dest/MC stable while wb_valid is high and
// wb_ready is low, and wb_ready never depends on wb_valid.
interface bus_c_writeback_if;
  logic       wb_valid;
  logic       wb_ready;
  logic [7:0] wb_data;
  logic [2:0] wb_dest;
  logic       MC;

  modport master (output wb_valid, output wb_data, output wb_dest, output MC,
                  input  wb_ready);
  modport slave  (input  wb_valid, input  wb_data, input  wb_dest, input  MC,
                  output wb_ready);
endinterface

// File: rtl/bus_c_writeback.sv
// Write-back end of the datapath: accepts results from bus C into a 2-entry
// write buffer and commits them in order into an 8x8 register file or the PC.
// Also supplies the bus-A register operand (bypassed from the buffer) and pc+1.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   bus (slave)     : bus C write handshake (wb_valid/wb_ready/wb_data/wb_dest/MC)
//   wb_hold         : 1 = suppress commit this cycle (accept still allowed)
//   pc_inc          : advance PC by one (a PC load commit takes priority)
//   reg_a_addr      : bus-A register read address
//   reg_a_data      : bus-A read data, newest buffered value wins
//   pc, pc_1        : current PC and PC + 1 (mod 256)
//   commit_cnt      : saturating count of committed writes
module bus_c_writeback #(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bus_c_writeback_if.slave        bus,
  input  logic                    wb_hold,
  input  logic                    pc_inc,
  input  logic [2:0]              reg_a_addr,
  output logic [7:0]              reg_a_data,
  output logic [7:0]              pc,
  output logic [7:0]              pc_1,
  output logic [7:0]              commit_cnt
);

  logic [7:0] regs_q     [8];
  logic [7:0] buf_data_q [2];
  logic [2:0] buf_dest_q [2];
  logic       buf_mc_q   [2];

  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] cnt_q, cnt_d;

  logic       accept;
  logic       commit;
  logic       young;

  // Ready comes from the registered count only, so there is no input-to-ready path.
  assign bus.wb_ready = (count_q != 2'(DEPTH));

  assign pc         = pc_q;
  assign pc_1       = pc_q + 8'd1;
  assign commit_cnt = cnt_q;

  always_comb begin
    accept  = bus.wb_valid && bus.wb_ready;
    // An entry accepted this edge is not yet in the buffer, so it cannot commit
    // until the next edge at the earliest.
    commit  = (count_q != 2'd0) && !wb_hold;

    count_d = count_q;
    case ({accept, commit})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    head_d = commit ? ~head_q : head_q;
    tail_d = accept ? ~tail_q : tail_q;

    // A PC load from the buffer beats the increment on the same edge.
    pc_d = pc_q;
    if (commit && buf_mc_q[head_q]) begin
      pc_d = buf_data_q[head_q];
    end else if (pc_inc) begin
      pc_d = pc_q + 8'd1;
    end

    cnt_d = cnt_q;
    if (commit && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Read bypass. The most recently written slot is the one just behind the
  // tail; it is valid whenever the buffer is non-empty. The head slot is a
  // distinct, older entry only when the buffer is full.
  always_comb begin
    young      = ~tail_q;
    reg_a_data = regs_q[reg_a_addr];
    if ((count_q != 2'd0) && !buf_mc_q[young] && (buf_dest_q[young] == reg_a_addr)) begin
      reg_a_data = buf_data_q[young];
    end else if ((count_q == 2'd2) && !buf_mc_q[head_q] &&
                 (buf_dest_q[head_q] == reg_a_addr)) begin
      reg_a_data = buf_data_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 8'h00;
      end
      for (int j = 0; j < 2; j++) begin
        buf_data_q[j] <= 8'h00;
        buf_dest_q[j] <= 3'd0;
        buf_mc_q[j]   <= 1'b0;
      end
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      pc_q    <= 8'h00;
      cnt_q   <= 8'h00;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        buf_data_q[tail_q] <= bus.wb_data;
        buf_dest_q[tail_q] <= bus.wb_dest;
        buf_mc_q[tail_q]   <= bus.MC;
      end
      if (commit && !buf_mc_q[head_q]) begin
        regs_q[buf_dest_q[head_q]] <= buf_data_q[head_q];
      end
    end
  end

endmodule

// File: tb/tb_bus_c_writeback.sv
module tb_bus_c_writeback;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       wb_hold;
  logic       pc_inc;
  logic [2:0] reg_a_addr;
  logic [7:0] reg_a_data;
  logic [7:0] pc;
  logic [7:0] pc_1;
  logic [7:0] commit_cnt;

  bus_c_writeback_if bus ();

  bus_c_writeback #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .wb_hold    (wb_hold),
    .pc_inc     (pc_inc),
    .reg_a_addr (reg_a_addr),
    .reg_a_data (reg_a_data),
    .pc         (pc),
    .pc_1       (pc_1),
    .commit_cnt (commit_cnt)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic [2:0] dest;
    logic       mc;
    logic       hold;
    logic       inc;
    logic [2:0] addr;
    logic       chk;
    logic       exp_ready;
    logic [7:0] exp_rd;
    logic [7:0] exp_pc;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic [2:0] ds, input logic m, input logic h,
                              input logic i, input logic [2:0] a, input logic c,
                              input logic er, input logic [7:0] erd,
                              input logic [7:0] epc, input logic [7:0] ecnt);
    vec_t t;
    t.rst_n = r; t.valid = v; t.data = d; t.dest = ds; t.mc = m; t.hold = h;
    t.inc = i; t.addr = a; t.chk = c; t.exp_ready = er; t.exp_rd = erd;
    t.exp_pc = epc; t.exp_cnt = ecnt;
    return t;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] data;
    logic [2:0] dest;
    logic       mc;
  } ent_t;

  ent_t       m_q[$];
  logic [7:0] m_regs[8];
  logic [7:0] m_pc;
  logic [7:0] m_cnt;
  logic       m_ok = 1'b0;

  function automatic logic [7:0] m_read(input logic [2:0] a);
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (!m_q[i].mc && m_q[i].dest == a) return m_q[i].data;
    end
    return m_regs[a];
  endfunction

  task automatic m_edge(input vec_t v);
    ent_t e;
    logic acc;
    logic com;
    if (!v.rst_n) begin
      m_q.delete();
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_pc  = 8'h00;
      m_cnt = 8'h00;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      acc = v.valid && (m_q.size() < 2);
      com = (m_q.size() > 0) && !v.hold;
      if (com) begin
        e = m_q.pop_front();
        if (e.mc) m_pc = e.data;
        else      m_regs[e.dest] = e.data;
        if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
      end
      if (!(com && e.mc) && v.inc) m_pc = m_pc + 8'd1;
      if (acc) begin
        e.data = v.data; e.dest = v.dest; e.mc = v.mc;
        m_q.push_back(e);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int cyc, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %02h expected %02h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  int cyc = 0;

  task automatic step(input vec_t v);
    @(negedge clk);
    rst_n        = v.rst_n;
    bus.wb_valid = v.valid;
    bus.wb_data  = v.data;
    bus.wb_dest  = v.dest;
    bus.MC       = v.mc;
    wb_hold      = v.hold;
    pc_inc       = v.inc;
    reg_a_addr   = v.addr;
    #1;
    if (v.chk) begin
      check("tbl_ready", cyc, {7'd0, bus.wb_ready}, {7'd0, v.exp_ready});
      check("tbl_rdata", cyc, reg_a_data, v.exp_rd);
      check("tbl_pc",    cyc, pc, v.exp_pc);
      check("tbl_pc_1",  cyc, pc_1, v.exp_pc + 8'd1);
      check("tbl_cnt",   cyc, commit_cnt, v.exp_cnt);
    end
    if (m_ok) begin
      check("mdl_ready", cyc, {7'd0, bus.wb_ready}, {7'd0, (m_q.size() < 2)});
      check("mdl_rdata", cyc, reg_a_data, m_read(v.addr));
      check("mdl_pc",    cyc, pc, m_pc);
      check("mdl_pc_1",  cyc, pc_1, m_pc + 8'd1);
      check("mdl_cnt",   cyc, commit_cnt, m_cnt);
    end
    @(posedge clk);
    m_edge(v);
    cyc++;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    rst_n = 1'b0; bus.wb_valid = 1'b0; bus.wb_data = 8'h00; bus.wb_dest = 3'd0;
    bus.MC = 1'b0; wb_hold = 1'b0; pc_inc = 1'b0; reg_a_addr = 3'd0;

    //                 rst v  data   ds  mc h  i  addr chk rdy rd     pc     cnt
    // reset held two edges with a write presented
    tbl.push_back(mk(0, 1, 8'hAA, 2, 0, 0, 0, 2, 0, 1, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(0, 1, 8'hAA, 2, 0, 0, 0, 2, 0, 1, 8'h00, 8'h00, 8'h00));
    for (int a = 0; a < 8; a++)
      tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 3'(a), 1, 1, 8'h00, 8'h00, 8'h00));
    // r3 = 5A, bypass then regfile
    tbl.push_back(mk(1, 1, 8'h5A, 3, 0, 0, 0, 3, 1, 1, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 3, 1, 1, 8'h5A, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 3, 1, 1, 8'h5A, 8'h00, 8'h01));
    // hold and full: r1 = 11, r1 = 22, third write refused
    tbl.push_back(mk(1, 1, 8'h11, 1, 0, 1, 0, 1, 1, 1, 8'h00, 8'h00, 8'h01));
    tbl.push_back(mk(1, 1, 8'h22, 1, 0, 1, 0, 1, 1, 1, 8'h11, 8'h00, 8'h01));
    tbl.push_back(mk(1, 1, 8'h33, 1, 0, 1, 0, 1, 1, 0, 8'h22, 8'h00, 8'h01));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h22, 8'h00, 8'h01));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 8'h22, 8'h00, 8'h02));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 8'h22, 8'h00, 8'h03));
    // PC load 0x40 with pc_inc held high; dest 3 must not bypass
    tbl.push_back(mk(1, 1, 8'h40, 3, 1, 0, 1, 3, 1, 1, 8'h5A, 8'h00, 8'h03));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 3, 1, 1, 8'h5A, 8'h01, 8'h03));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 3, 1, 1, 8'h5A, 8'h40, 8'h04));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 3, 1, 1, 8'h5A, 8'h41, 8'h04));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 3, 1, 1, 8'h5A, 8'h42, 8'h04));
    // wrap: load FF then increment
    tbl.push_back(mk(1, 1, 8'hFF, 0, 1, 0, 0, 3, 1, 1, 8'h5A, 8'h42, 8'h04));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 3, 1, 1, 8'h5A, 8'h42, 8'h04));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 3, 1, 1, 8'h5A, 8'hFF, 8'h05));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 3, 1, 1, 8'h5A, 8'h00, 8'h05));
    // reset with two writes pending
    tbl.push_back(mk(1, 1, 8'h77, 5, 0, 1, 0, 5, 1, 1, 8'h00, 8'h00, 8'h05));
    tbl.push_back(mk(1, 1, 8'h66, 6, 0, 1, 0, 5, 1, 1, 8'h77, 8'h00, 8'h05));
    tbl.push_back(mk(0, 1, 8'h55, 5, 0, 1, 0, 5, 1, 0, 8'h77, 8'h00, 8'h05));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 5, 1, 1, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 6, 1, 1, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 3, 1, 1, 8'h00, 8'h00, 8'h00));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      v.rst_n = ($urandom_range(0, 99) != 0);
      v.valid = ($urandom_range(0, 3) != 0);
      v.data  = 8'($urandom);
      v.dest  = 3'($urandom_range(0, 7));
      v.mc    = ($urandom_range(0, 5) == 0);
      v.hold  = ($urandom_range(0, 2) == 0);
      v.inc   = ($urandom_range(0, 1) == 1);
      v.addr  = 3'($urandom_range(0, 7));
      v.chk   = 1'b0;
      v.exp_ready = 1'b0; v.exp_rd = 8'h00; v.exp_pc = 8'h00; v.exp_cnt = 8'h00;
      step(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
